fetch_stall_unit: RTL and testbench
===================================

Name: fetch_stall_unit

Overview:
- Fetch-side responder to the hazard controller's stall request.
- Owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- On `PCStall` it freezes the PC and IF/ID; on a taken branch it redirects the PC and flushes IF/ID with a NOP bubble.
- A consecutive-stall watchdog flags a hazard controller that never releases the stall.

Parameters:
- `ADDR_W`, 16, PC / instruction-memory address width (word addressed).
- `INSTR_W`, 16, instruction width.
- `RESET_PC`, 0, PC value loaded on reset.
- `NOP_INSTR`, 0, encoding inserted into IF/ID as a bubble.
- `MAX_STALL`, 15, consecutive stall cycles tolerated before timeout (must be ≥ 1).
- `CNT_W`, 4, stall counter width (≥ clog2(MAX_STALL+1)).

Ports:
- `clock`  in  1  — single system clock, rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `PCStall`  in  1  — stall request from the hazard controller; hold PC and IF/ID.
- `BranchTaken`  in  1  — redirect request from the branch-resolve stage.
- `BranchTarget`  in  ADDR_W  — redirect address, valid with `BranchTaken`.
- `imemaddr`  out  ADDR_W  — instruction-memory address; always equals the PC register.
- `imemrdata`  in  INSTR_W  — combinational instruction-memory read data for `imemaddr`.
- `IFID`  out  INSTR_W  — IF/ID instruction register.
- `IFIDPC`  out  ADDR_W  — IF/ID PC+1 register.
- `IFIDValid`  out  1  — 1 when `IFID` holds a fetched instruction, 0 for a bubble.
- `StallCount`  out  CNT_W  — current consecutive-stall count, saturating.
- `StallTimeout`  out  1  — sticky watchdog flag.

Behaviour:
- **Reset** (`reset`=0, asynchronous, any state):
  - PC = `RESET_PC`; `IFID` = `NOP_INSTR`; `IFIDPC` = 0; `IFIDValid` = 0.
  - `StallCount` = 0; `StallTimeout` = 0; FSM = RUN.
  - Reset asserted mid-stall or mid-redirect discards all in-flight state.
- **Per-cycle priority** on the rising edge: `BranchTaken` > `PCStall` > normal.
- **Normal** (neither input asserted):
  - PC ← PC+1, wrapping 2^ADDR_W−1 → 0.
  - `IFID` ← `imemrdata`; `IFIDPC` ← PC+1 (same wrap); `IFIDValid` ← 1.
- **Stall** (`PCStall`=1, `BranchTaken`=0): PC, `IFID`, `IFIDPC` and `IFIDValid` all hold.
- **Redirect** (`BranchTaken`=1, regardless of `PCStall`):
  - PC ← `BranchTarget`; `IFID` ← `NOP_INSTR`; `IFIDPC` ← `BranchTarget`; `IFIDValid` ← 0.
  - The wrong-path fetch is never latched.
- **Latency:**
  - Instruction at address A appears on `IFID` one cycle after `imemaddr`=A with no stall.
  - First valid `IFID` appears one edge after reset release.
- **FSM states:** RUN, STALLED, TIMEOUT.
  - **RUN:**
    - `PCStall`=1 and `BranchTaken`=0 → STALLED, `StallCount` ← 1.
    - Otherwise stay in RUN with `StallCount` = 0.
  - **STALLED:**
    - `PCStall`=0 or `BranchTaken`=1 → RUN, `StallCount` ← 0.
    - Otherwise `StallCount` ← `StallCount`+1.
    - If the incremented value exceeds `MAX_STALL` → TIMEOUT and `StallTimeout` ← 1.
  - **TIMEOUT:**
    - `StallTimeout` stays 1 until reset.
    - Datapath keeps obeying `PCStall` and `BranchTaken` exactly as in RUN/STALLED.
    - `StallCount` saturates at `MAX_STALL` while stalled and clears to 0 when not stalled.
- `StallCount` never wraps.
- Simultaneous `PCStall` and `BranchTaken`: redirect wins, and the cycle is not counted as a stall.
- `BranchTarget` is ignored when `BranchTaken`=0.
- `imemaddr` is a direct register output with no combinational path from inputs.

Decomposition:
- Shared pipeline package holds:
  - `ADDR_W` and `INSTR_W` defaults;
  - the `NOP_INSTR` encoding (shared with the ID/EX bubble insertion and the hazard controller);
  - FSM state encodings RUN=2'd0, STALLED=2'd1, TIMEOUT=2'd2.
- One natural sub-module, `stall_watchdog`: the FSM plus saturating counter.
  - Inputs: `PCStall`, `BranchTaken`.
  - Outputs: `StallCount`, `StallTimeout`.
- PC and IF/ID registers stay in the top module.

Test Plan:
1. Reset then free-run, `imemrdata`=0x1000+addr:
   - after release, `IFID`=0x1000, 0x1001, 0x1002 on successive edges;
   - `IFIDPC`=1, 2, 3; `IFIDValid`=1 from the first edge.
2. `PCStall` high 3 cycles at PC=5:
   - `imemaddr` holds 5 and `IFID` holds the word from address 4;
   - `StallCount` = 1, 2, 3, then 0 after release;
   - PC advances to 6 the cycle after release.
3. `BranchTaken`=1, `BranchTarget`=0x0040, with `PCStall`=1 in the same cycle:
   - next edge PC=0x0040, `IFID`=`NOP_INSTR`, `IFIDValid`=0, `StallCount`=0;
   - following edge `IFID`=word at 0x0040, `IFIDValid`=1.
4. `PCStall` held 17 cycles with `MAX_STALL`=15:
   - `StallTimeout` rises when the count would reach 16 and `StallCount` saturates at 15;
   - after stall release `StallTimeout` stays 1 while fetch resumes;
   - `StallTimeout` clears only on reset.
5. PC wrap: force PC to 0xFFFF via `BranchTaken`, then run one cycle → `imemaddr`=0x0000 and `IFIDPC`=0x0000.
6. Assert `reset` asynchronously mid-stall (between clock edges):
   - all outputs go to reset values immediately, without a clock edge;
   - fetch restarts from `RESET_PC` after release.

Source files
------------

// File: rtl/fetch_stall_unit_pkg.sv
// fetch_stall_unit_pkg: shared pipeline widths, bubble encoding and watchdog state encoding.
package fetch_stall_unit_pkg;
  localparam int PKG_ADDR_W = 16;
  localparam int PKG_INSTR_W = 16;
  localparam logic [15:0] PKG_NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALLED = 2'd1,
    TIMEOUT = 2'd2
  } stall_state_e;
endpackage

// File: rtl/fetch_stall_unit_stall_watchdog.sv
// stall_watchdog: counts consecutive stall cycles and latches a timeout when the stall never releases.
module stall_watchdog
  import fetch_stall_unit_pkg::*;
#(
  parameter int MAX_STALL = 15,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PCStall,
  input  logic             BranchTaken,
  output logic [CNT_W-1:0] StallCount,
  output logic             StallTimeout
);
  localparam logic [CNT_W:0] MAX_WIDE = (CNT_W+1)'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);
  stall_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stall;
  logic [CNT_W:0] inc;
  logic over;
  // a redirect in the same cycle wins, so it never counts as a stall
  assign stall = PCStall & ~BranchTaken;
  assign inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign over = inc > MAX_WIDE;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      RUN: begin
        state_d = stall ? STALLED : RUN;
        cnt_d = stall ? CNT_W'(1) : '0;
      end
      STALLED: begin
        state_d = !stall ? RUN : over ? TIMEOUT : STALLED;
        cnt_d = !stall ? '0 : over ? CNT_MAX : inc[CNT_W-1:0];
      end
      TIMEOUT: cnt_d = !stall ? '0 : over ? CNT_MAX : inc[CNT_W-1:0];
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign StallCount = cnt_q;
  assign StallTimeout = state_q == TIMEOUT;
endmodule

// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit: PC and IF/ID registers obeying stall and branch redirect, plus a stall watchdog.
module fetch_stall_unit
  import fetch_stall_unit_pkg::*;
#(
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int INSTR_W = PKG_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PKG_NOP_INSTR),
  parameter int MAX_STALL = 15,
  parameter int CNT_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               PCStall,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  output logic [ADDR_W-1:0]  imemaddr,
  input  logic [INSTR_W-1:0] imemrdata,
  output logic [INSTR_W-1:0] IFID,
  output logic [ADDR_W-1:0]  IFIDPC,
  output logic               IFIDValid,
  output logic [CNT_W-1:0]   StallCount,
  output logic               StallTimeout
);
  logic [ADDR_W-1:0] pc_q, pc_d, ifidpc_q, ifidpc_d, pc_inc;
  logic [INSTR_W-1:0] ifid_q, ifid_d;
  logic valid_q, valid_d;
  assign pc_inc = pc_q + ADDR_W'(1);
  always_comb begin
    pc_d = BranchTaken ? BranchTarget : PCStall ? pc_q : pc_inc;
    ifid_d = BranchTaken ? NOP_INSTR : PCStall ? ifid_q : imemrdata;
    ifidpc_d = BranchTaken ? BranchTarget : PCStall ? ifidpc_q : pc_inc;
    valid_d = BranchTaken ? 1'b0 : PCStall ? valid_q : 1'b1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ifid_q <= NOP_INSTR;
      ifidpc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ifid_q <= ifid_d;
      ifidpc_q <= ifidpc_d;
      valid_q <= valid_d;
    end
  end
  assign imemaddr = pc_q;
  assign IFID = ifid_q;
  assign IFIDPC = ifidpc_q;
  assign IFIDValid = valid_q;
  stall_watchdog #(
    .MAX_STALL(MAX_STALL),
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clock(clock),
    .reset(reset),
    .PCStall(PCStall),
    .BranchTaken(BranchTaken),
    .StallCount(StallCount),
    .StallTimeout(StallTimeout)
  );
endmodule

// File: tb/tb_fetch_stall_unit.sv
// tb_fetch_stall_unit: directed test-plan sequences plus random stall/branch traffic against a behavioural model.
module tb_fetch_stall_unit;
  localparam int MAX = 15;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic PCStall = 1'b0;
  logic BranchTaken = 1'b0;
  logic [15:0] BranchTarget = '0;
  logic [15:0] imemaddr, imemrdata, IFID, IFIDPC;
  logic IFIDValid;
  logic [3:0] StallCount;
  logic StallTimeout;
  int checks = 0;
  int errors = 0;
  logic [15:0] m_pc, m_ifid, m_ifidpc;
  bit m_v, m_to;
  int m_run;

  always #5 clock = ~clock;
  assign imemrdata = 16'h1000 + imemaddr;

  fetch_stall_unit #(.MAX_STALL(MAX), .CNT_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .PCStall(PCStall),
    .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget),
    .imemaddr(imemaddr),
    .imemrdata(imemrdata),
    .IFID(IFID),
    .IFIDPC(IFIDPC),
    .IFIDValid(IFIDValid),
    .StallCount(StallCount),
    .StallTimeout(StallTimeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_ifid = 16'h0000;
    m_ifidpc = 16'h0000;
    m_v = 1'b0;
    m_run = 0;
    m_to = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"}, 32'(imemaddr), 32'(m_pc));
    check({tag, ".ifid"}, 32'(IFID), 32'(m_ifid));
    check({tag, ".ifidpc"}, 32'(IFIDPC), 32'(m_ifidpc));
    check({tag, ".valid"}, 32'(IFIDValid), 32'(m_v));
    check({tag, ".count"}, 32'(StallCount), 32'(m_run > MAX ? MAX : m_run));
    check({tag, ".timeout"}, 32'(StallTimeout), 32'(m_to));
  endtask

  task automatic cycle(input bit s, input bit b, input logic [15:0] t, input string tag);
    PCStall = s;
    BranchTaken = b;
    BranchTarget = t;
    @(posedge clock);
    if (b) begin
      m_pc = t;
      m_ifid = 16'h0000;
      m_ifidpc = t;
      m_v = 1'b0;
    end else if (!s) begin
      m_ifid = 16'h1000 + m_pc;
      m_pc = m_pc + 16'd1;
      m_ifidpc = m_pc;
      m_v = 1'b1;
    end
    m_run = (s && !b) ? m_run + 1 : 0;
    if (m_run > MAX) m_to = 1'b1;
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int burst;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b1;
    cycle(0, 0, 0, "t1");
    check("t1_first_ifid", 32'(IFID), 32'h1000);
    cycle(0, 0, 0, "t1");
    cycle(0, 0, 0, "t1");
    check("t1_third_ifidpc", 32'(IFIDPC), 32'd3);
    cycle(0, 0, 0, "t2pre");
    cycle(0, 0, 0, "t2pre");
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0, "t2");
      check("t2_hold_addr", 32'(imemaddr), 32'd5);
      check("t2_hold_ifid", 32'(IFID), 32'h1004);
      check("t2_count", 32'(StallCount), 32'(i));
    end
    cycle(0, 0, 0, "t2rel");
    check("t2_addr_after", 32'(imemaddr), 32'd6);
    check("t2_count_after", 32'(StallCount), 32'd0);
    cycle(1, 1, 16'h0040, "t3");
    check("t3_redirect_valid", 32'(IFIDValid), 32'd0);
    check("t3_redirect_count", 32'(StallCount), 32'd0);
    cycle(0, 0, 0, "t3");
    check("t3_target_ifid", 32'(IFID), 32'h1040);
    for (int i = 1; i <= 17; i++) cycle(1, 0, 0, "t4");
    check("t4_timeout", 32'(StallTimeout), 32'd1);
    check("t4_saturate", 32'(StallCount), 32'd15);
    repeat (3) cycle(0, 0, 0, "t4rel");
    check("t4_sticky", 32'(StallTimeout), 32'd1);
    cycle(0, 1, 16'hFFFF, "t5");
    cycle(0, 0, 0, "t5");
    check("t5_wrap_addr", 32'(imemaddr), 32'd0);
    check("t5_wrap_ifidpc", 32'(IFIDPC), 32'd0);
    cycle(1, 0, 0, "t6");
    cycle(1, 0, 0, "t6");
    async_reset("t6_async");
    cycle(0, 0, 0, "t6_restart");
    check("t6_restart_ifid", 32'(IFID), 32'h1000);
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      bit s, b;
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(5, 20);
      s = burst > 0 ? 1'b1 : ($urandom_range(0, 9) < 4);
      b = burst > 0 ? 1'b0 : ($urandom_range(0, 9) == 0);
      if (burst > 0) burst--;
      cycle(s, b, 16'($urandom), "rand");
      if (i % 150 == 149) async_reset("rand_reset");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
